// File: rtl/dac_pkg.sv
// Shared constants and helpers for the DAC SPI output stage.
// Frame layout: {2 don't-care, 2 power-down, 12 data}, MSB first.
package dac_pkg;
  localparam int FRAME_W = 16;
  localparam int DAC_W   = 12;
  localparam int GAIN_W  = 9;

  localparam logic [GAIN_W-1:0] UNITY_GAIN = 9'd256;
  localparam logic [1:0]        PD_NORMAL  = 2'b00;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t SCALE = 2'd1;
  localparam state_t SHIFT = 2'd2;
  localparam state_t GAP   = 2'd3;

  function automatic logic [GAIN_W-1:0] clamp_gain(input logic [GAIN_W-1:0] g);
    return (g > UNITY_GAIN) ? UNITY_GAIN : g;
  endfunction
endpackage

// File: rtl/sample_scaler.sv
// Captures the sample and clamped gain at accept and presents the scaled
// 12-bit DAC code during SCALE.
module sample_scaler
  import dac_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [15:0]       sample,
  input  logic [GAIN_W-1:0] gain,
  output logic [DAC_W-1:0]  code
);

  logic [15:0]       sample_q;
  logic [GAIN_W-1:0] gain_q;
  logic [24:0]       prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q <= '0;
      gain_q   <= '0;
    end else if (load) begin
      sample_q <= sample;
      gain_q   <= clamp_gain(gain);
    end
  end

  // Gain is at most unity, so prod[24] is always zero; code is prod[23:12].
  assign prod = {9'd0, sample_q} * {16'd0, gain_q};
  assign code = DAC_W'(prod >> 12);

endmodule

// File: rtl/dac_spi_out.sv
// Gain-scaled sample to 16-bit SPI frame serialiser for a 12-bit DAC.
//
// state | meaning
// IDLE  | waiting for a sample; s_ready follows ena
// SCALE | scaled code settles, frame loaded into shift register
// SHIFT | 16 bit periods, SCLK high half then low half, DAC samples on fall
// GAP   | sync_n high for GAP_CYC cycles before the next frame
module dac_spi_out
  import dac_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic [15:0]       s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [GAIN_W-1:0] gain,
  output logic              dac_sclk,
  output logic              dac_sync_n,
  output logic              dac_din,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);

  state_t             state;
  logic [FRAME_W-1:0] shreg;
  logic [FRAME_W-1:0] frame;
  logic [3:0]         bit_cnt;
  logic [7:0]         div_cnt;
  logic [7:0]         gap_cnt;
  logic [DAC_W-1:0]   code;
  logic               accept;

  assign s_ready = ena & (state == IDLE) & ~rst;
  assign accept  = s_valid & s_ready;
  assign frame   = {2'b00, PD_NORMAL, code};

  sample_scaler u_scaler (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .sample (s_data),
    .gain   (gain),
    .code   (code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      gap_cnt    <= '0;
      dac_sclk   <= 1'b1;
      dac_sync_n <= 1'b1;
      dac_din    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state <= SCALE;
            busy  <= 1'b1;
          end
        end
        SCALE: begin
          shreg      <= frame;
          dac_din    <= frame[FRAME_W-1];
          dac_sync_n <= 1'b0;
          dac_sclk   <= 1'b1;
          bit_cnt    <= 4'd15;
          div_cnt    <= DIV_LAST;
          state      <= SHIFT;
        end
        SHIFT: begin
          if (div_cnt != 8'd0) begin
            div_cnt <= div_cnt - 8'd1;
          end else begin
            div_cnt <= DIV_LAST;
            if (dac_sclk) begin
              dac_sclk <= 1'b0;
            end else if (bit_cnt == 4'd0) begin
              state      <= GAP;
              dac_sync_n <= 1'b1;
              dac_sclk   <= 1'b1;
              dac_din    <= 1'b0;
              gap_cnt    <= GAP_LAST;
            end else begin
              // Data changes only together with the SCLK rising edge.
              dac_sclk <= 1'b1;
              bit_cnt  <= bit_cnt - 4'd1;
              shreg    <= shreg << 1;
              dac_din  <= shreg[FRAME_W-2];
            end
          end
        end
        GAP: begin
          if (gap_cnt != 8'd0) begin
            gap_cnt <= gap_cnt - 8'd1;
          end else begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_out.sv
// Self-checking bench for dac_spi_out: table vectors, hand-written corner
// sequences and random samples against an arithmetic reference model.
module tb_dac_spi_out;

  localparam int CLK_DIV  = 4;
  localparam int GAP_CYC  = 4;
  localparam int DONE_CYC = 2 + 32 * CLK_DIV + GAP_CYC;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [8:0]  gain;
  logic        dac_sclk;
  logic        dac_sync_n;
  logic        dac_din;
  logic        busy;
  logic        frame_done;

  dac_spi_out #(.CLK_DIV(CLK_DIV), .GAP_CYC(GAP_CYC)) dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .gain       (gain),
    .dac_sclk   (dac_sclk),
    .dac_sync_n (dac_sync_n),
    .dac_din    (dac_din),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [8:0]  g;
    logic [8:0]  g_after;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] frame;
    int          sync_low;
    int          falls;
    int          first_fall;
    int          done_cyc;
    int          ready_cyc;
    int          done_pulses;
    logic        busy1;
  } res_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference: code = floor(sample * min(gain,256) / 4096), upper nibble zero.
  function automatic logic [15:0] model(input int d, input int g);
    int ge;
    ge = (g > 256) ? 256 : g;
    return 16'((d * ge) / 4096);
  endfunction

  task automatic accept(input logic [15:0] d, input logic [8:0] g);
    int t;
    t = 0;
    @(negedge clk);
    while (!s_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("accept_ready", s_ready, 1);
    s_data  = d;
    gain    = g;
    s_valid = 1'b1;
    @(posedge clk);
  endtask

  // Samples once per cycle on the falling clk; k counts cycles since accept.
  task automatic capture(input int k0, input logic keep_valid, input int ena_drop,
                         input logic [8:0] g_after, output res_t r);
    logic prev;
    r.frame = '0; r.sync_low = 0; r.falls = 0; r.first_fall = -1;
    r.done_cyc = -1; r.ready_cyc = -1; r.done_pulses = 0; r.busy1 = 1'b0;
    prev = 1'b1;
    for (int k = k0; k < k0 + 400; k++) begin
      @(negedge clk);
      if (k == k0) r.busy1 = busy;
      if (!dac_sync_n) r.sync_low++;
      if (prev && !dac_sclk) begin
        r.frame = {r.frame[14:0], dac_din};
        r.falls++;
        if (r.first_fall < 0) r.first_fall = k;
        if (r.falls == ena_drop) ena = 1'b0;
      end
      prev = dac_sclk;
      if (frame_done) begin
        r.done_pulses++;
        if (r.done_cyc < 0) r.done_cyc = k;
      end
      if (s_ready && r.ready_cyc < 0) r.ready_cyc = k;
      if (k == k0) begin
        if (!keep_valid) s_valid = 1'b0;
        gain   = g_after;
        s_data = ~s_data;
      end
      if (r.done_cyc >= 0 && k == r.done_cyc + 1) break;
    end
    if (r.done_cyc < 0) chk("frame_done_timeout", 0, 1);
  endtask

  task automatic check_frame(input string tag, input res_t r, input logic [15:0] exp,
                             input logic expect_ready);
    chk({tag, "_frame"}, r.frame, exp);
    chk({tag, "_sync_low_cycles"}, r.sync_low, 32 * CLK_DIV);
    chk({tag, "_sclk_falls"}, r.falls, 16);
    chk({tag, "_first_fall_cycle"}, r.first_fall, 2 + CLK_DIV);
    chk({tag, "_done_cycle"}, r.done_cyc, DONE_CYC);
    chk({tag, "_done_pulses"}, r.done_pulses, 1);
    chk({tag, "_busy_after_accept"}, r.busy1, 1);
    if (expect_ready) chk({tag, "_ready_cycle"}, r.ready_cyc, DONE_CYC);
  endtask

  initial begin
    vec_t        vecs[8];
    res_t        r;
    logic [15:0] d;
    logic [8:0]  g;
    logic        prev;
    int          f;

    vecs[0] = '{16'hFFFF, 9'd256, 9'd256, 16'h0FFF};
    vecs[1] = '{16'h8000, 9'd128, 9'd128, 16'h0400};
    vecs[2] = '{16'h1234, 9'd300, 9'd0,   16'h0123};
    vecs[3] = '{16'h0000, 9'd256, 9'd256, 16'h0000};
    vecs[4] = '{16'hFFFF, 9'd0,   9'd256, 16'h0000};
    vecs[5] = '{16'hABCD, 9'd511, 9'd0,   16'h0ABC};
    vecs[6] = '{16'h1000, 9'd1,   9'd1,   16'h0001};
    vecs[7] = '{16'hFFFF, 9'd255, 9'd255, 16'h0FEF};

    rst = 1'b1; ena = 1'b0; s_valid = 1'b0; s_data = '0; gain = '0;
    #1;
    chk("rst_sclk", dac_sclk, 1);
    chk("rst_sync_n", dac_sync_n, 1);
    chk("rst_din", dac_din, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ready", s_ready, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ena = 1'b1;

    for (int i = 0; i < 8; i++) begin
      accept(vecs[i].d, vecs[i].g);
      capture(1, 1'b0, -1, vecs[i].g_after, r);
      check_frame($sformatf("vec%0d", i), r, vecs[i].exp, 1'b1);
    end

    // Back-to-back with s_valid held, then ena dropped during the second frame.
    accept(16'h0F0F, 9'd256);
    capture(1, 1'b1, -1, 9'd256, r);
    check_frame("b2b", r, model(16'h0F0F, 256), 1'b1);
    chk("b2b_next_busy", busy, 1);
    capture(2, 1'b1, 5, 9'd256, r);
    check_frame("enadrop", r, model(16'hF0F0, 256), 1'b0);
    chk("enadrop_no_ready", r.ready_cyc, -1);
    repeat (6) begin
      @(negedge clk);
      chk("enadrop_idle_busy", busy, 0);
    end
    s_data = 16'h5555;
    gain   = 9'd256;
    ena    = 1'b1;
    #1;
    chk("reena_ready", s_ready, 1);
    @(posedge clk);
    capture(1, 1'b0, -1, 9'd256, r);
    check_frame("reena", r, 16'h0555, 1'b1);

    // Reset during bit 7 (ninth falling edge).
    accept(16'hFFFF, 9'd256);
    @(negedge clk);
    s_valid = 1'b0;
    f = 0;
    prev = 1'b1;
    for (int t = 0; t < 300 && f < 9; t++) begin
      @(negedge clk);
      if (prev && !dac_sclk) f++;
      prev = dac_sclk;
    end
    chk("rst_reach_bit7", f, 9);
    rst = 1'b1;
    #1;
    chk("midrst_sclk", dac_sclk, 1);
    chk("midrst_sync_n", dac_sync_n, 1);
    chk("midrst_din", dac_din, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", frame_done, 0);
    chk("midrst_ready", s_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("postrst_no_done", frame_done, 0);
      chk("postrst_idle", busy, 0);
    end
    accept(16'h1234, 9'd300);
    capture(1, 1'b0, -1, 9'd0, r);
    check_frame("postrst", r, 16'h0123, 1'b1);

    for (int i = 0; i < 20; i++) begin
      d = 16'($urandom);
      g = 9'($urandom_range(0, 511));
      accept(d, g);
      capture(1, 1'b0, -1, 9'($urandom), r);
      check_frame($sformatf("rand%0d", i), r, model(d, g), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
